// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic cluster.
// Contents:
//   DIV_WIDTH    - default operand width of the sequential divider
//   DIV_CNT_W    - iteration counter width for the default width
//   div_state_e  - divider FSM state encoding (IDLE, RUN, DONE)
package arith_pkg;

    localparam int DIV_WIDTH = 4;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/addsub_w.sv
// Parameterized ripple-carry adder/subtractor.
// Each b bit is XORed with mode and mode feeds the carry-in, so
// mode=0 gives a+b and mode=1 gives a-b (cout=1 means no borrow).
// Ports:
//   a, b  in  W  operands
//   mode  in  1  0 = add, 1 = subtract
//   sum   out W  result
//   cout  out 1  carry out of the top stage
module addsub_w #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mode,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] carry_s;

    assign carry_s[0] = mode;

    for (genvar i = 0; i < W; i++) begin : g_stage
        logic bx_s;
        assign bx_s           = b[i] ^ mode;
        assign sum[i]         = a[i] ^ bx_s ^ carry_s[i];
        assign carry_s[i + 1] = (a[i] & bx_s) | (carry_s[i] & (a[i] ^ bx_s));
    end

    assign cout = carry_s[W];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with a start/busy/done handshake.
// One quotient bit is produced per RUN cycle by shift-and-subtract on a
// shared ripple add/sub of width WIDTH+1.
// Optional feature: define DIV_SIGNED_EN for two's-complement operands
// (magnitudes taken on accept, signs applied when results are written).
// Ports:
//   clk          in  1      clock, rising edge
//   rst          in  1      synchronous active-high reset
//   start        in  1      request, sampled only in IDLE
//   dividend     in  WIDTH  captured on accepted start
//   divisor      in  WIDTH  captured on accepted start
//   busy         out 1      high in RUN and DONE
//   done         out 1      one-cycle pulse, results valid from this cycle
//   quotient     out WIDTH  result, held until next accepted start
//   remainder    out WIDTH  result, held until next accepted start
//   div_by_zero  out 1      divisor was zero
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WIDTH:0]    r_q;
    logic [WIDTH-1:0]  q_q;
    logic [WIDTH-1:0]  d_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  quot_q;
    logic [WIDTH-1:0]  rem_q;
    logic              dbz_q;

    logic [WIDTH:0]    r_shift_s;
    logic [WIDTH:0]    trial_s;
    logic              cout_s;
    logic [WIDTH:0]    r_iter_s;
    logic [WIDTH-1:0]  q_iter_s;
    logic [WIDTH-1:0]  a_mag_s;
    logic [WIDTH-1:0]  b_mag_s;
    logic [WIDTH-1:0]  fin_q_s;
    logic [WIDTH-1:0]  fin_r_s;
    logic              unused_s;

`ifdef DIV_SIGNED_EN
    logic              qneg_q;
    logic              rneg_q;
    logic [WIDTH-1:0]  one_s;
    assign one_s = {{(WIDTH-1){1'b0}}, 1'b1};
`endif

    // The shift always discards R's top bit, so it is never read back.
    assign unused_s = r_q[WIDTH];

    addsub_w #(.W(WIDTH + 1)) u_addsub (
        .a    (r_shift_s),
        .b    ({1'b0, d_q}),
        .mode (1'b1),
        .sum  (trial_s),
        .cout (cout_s)
    );

    // One restoring iteration: shift in the next dividend bit, keep the
    // trial difference only when the subtraction did not borrow.
    always_comb begin
        r_shift_s = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        if (cout_s) begin
            r_iter_s = trial_s;
            q_iter_s = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            r_iter_s = r_shift_s;
            q_iter_s = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    // Operand magnitudes on accept and final sign correction of results.
    always_comb begin
`ifdef DIV_SIGNED_EN
        a_mag_s = dividend[WIDTH-1] ? (~dividend + one_s) : dividend;
        b_mag_s = divisor[WIDTH-1]  ? (~divisor + one_s)  : divisor;
        fin_q_s = qneg_q ? (~q_iter_s + one_s) : q_iter_s;
        fin_r_s = rneg_q ? (~r_iter_s[WIDTH-1:0] + one_s) : r_iter_s[WIDTH-1:0];
`else
        a_mag_s = dividend;
        b_mag_s = divisor;
        fin_q_s = q_iter_s;
        fin_r_s = r_iter_s[WIDTH-1:0];
`endif
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            r_q     <= {(WIDTH+1){1'b0}};
            q_q     <= {WIDTH{1'b0}};
            d_q     <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        d_q    <= b_mag_s;
                        q_q    <= a_mag_s;
                        r_q    <= {(WIDTH+1){1'b0}};
                        cnt_q  <= CNT_W'(WIDTH);
                        busy_q <= 1'b1;
`ifdef DIV_SIGNED_EN
                        qneg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rneg_q <= dividend[WIDTH-1];
`endif
                        if (divisor == {WIDTH{1'b0}}) begin
                            // Zero divisor skips RUN: results are known now.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            quot_q  <= {WIDTH{1'b1}};
                            rem_q   <= dividend;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            quot_q  <= {WIDTH{1'b0}};
                            rem_q   <= {WIDTH{1'b0}};
                            dbz_q   <= 1'b0;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_q   <= r_iter_s;
                    q_q   <= q_iter_s;
                    cnt_q <= cnt_q - CNT_W'(1);
                    // Last iteration: publish results so they are valid in DONE.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        quot_q  <= fin_q_s;
                        rem_q   <= fin_r_s;
                    end else begin
                        done_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=4).
// Expected values are hand-computed; the DIV_SIGNED_EN build reinterprets
// the same bit patterns as two's complement.
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks;
    int failures;

`ifdef DIV_SIGNED_EN
    // 13=-3, 15=-1, 9=-7 as signed values
    localparam logic [3:0] E13_3_Q = 4'hF, E13_3_R = 4'h0;
    localparam logic [3:0] E15_1_Q = 4'hF, E15_1_R = 4'h0;
    localparam logic [3:0] E9_2_Q  = 4'hD, E9_2_R  = 4'hF;
`else
    localparam logic [3:0] E13_3_Q = 4'h4, E13_3_R = 4'h1;
    localparam logic [3:0] E15_1_Q = 4'hF, E15_1_R = 4'h0;
    localparam logic [3:0] E9_2_Q  = 4'h4, E9_2_R  = 4'h1;
`endif

    seq_divider #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one division and wait for it; lat is the cycle index of done
    // counting the cycle after the accepting edge as 1 (0 = timed out).
    task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                           output int lat, output int ndone);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        lat   = 0;
        ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ndone++;
                if (lat == 0) lat = k;
            end
            if (lat != 0 && !busy) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = 4'h0; divisor = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 11'b0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dbz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, nd;
        run_div(4'd13, 4'd3, lat, nd);
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL basic_latency: got %0d want 5", lat); end
        checks++;
        if (nd !== 1) begin failures++; $display("FAIL basic_done_count: got %0d want 1", nd); end
        checks++;
        if (quotient !== E13_3_Q || remainder !== E13_3_R || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: got q=%h r=%h dbz=%b want q=%h r=%h dbz=0",
                     quotient, remainder, div_by_zero, E13_3_Q, E13_3_R);
        end
    endtask

    task automatic test_div_zero();
        int lat, nd;
        run_div(4'd7, 4'd0, lat, nd);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL dbz_latency: got %0d want 1", lat); end
        checks++;
        if (quotient !== 4'hF || remainder !== 4'h7 || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL dbz_result: got q=%h r=%h dbz=%b want q=f r=7 dbz=1",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_hold();
        int lat, nd;
        run_div(4'd15, 4'd1, lat, nd);
        repeat (4) @(negedge clk);
        checks++;
        if (quotient !== E15_1_Q || remainder !== E15_1_R || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_15_1: got q=%h r=%h done=%b busy=%b want q=%h r=%h done=0 busy=0",
                     quotient, remainder, done, busy, E15_1_Q, E15_1_R);
        end
        run_div(4'd0, 4'd5, lat, nd);
        checks++;
        if (lat !== 5 || quotient !== 4'h0 || remainder !== 4'h0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL zero_dividend: got lat=%0d q=%h r=%h dbz=%b want lat=5 q=0 r=0 dbz=0",
                     lat, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nd;
        bit seen_done_busy;
        @(negedge clk);
        dividend = 4'd9;
        divisor  = 4'd2;
        start    = 1'b1;
        @(posedge clk);
        lat = 0; nd = 0; seen_done_busy = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            dividend = 4'(k);
            divisor  = 4'(k + 3);
            if (done) begin
                nd++;
                if (lat == 0) lat = k;
                if (!busy) seen_done_busy = 1'b0;
            end
            if (lat != 0 && !busy) begin
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (lat !== 5 || nd !== 1) begin
            failures++;
            $display("FAIL b2b_done: got lat=%0d dones=%0d want lat=5 dones=1", lat, nd);
        end
        checks++;
        if (!seen_done_busy) begin
            failures++;
            $display("FAIL b2b_busy_in_done: got busy=0 in done cycle, want 1");
        end
        checks++;
        if (quotient !== E9_2_Q || remainder !== E9_2_R) begin
            failures++;
            $display("FAIL b2b_result: got q=%h r=%h want q=%h r=%h",
                     quotient, remainder, E9_2_Q, E9_2_R);
        end
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        checks++;
        if (nd !== 0) begin
            failures++;
            $display("FAIL b2b_no_queue: got %0d active cycles want 0", nd);
        end
    endtask

    task automatic test_reset_mid();
        int lat, nd;
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 11'b0) begin
            failures++;
            $display("FAIL midrun_reset: got busy=%b done=%b q=%h r=%h dbz=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        checks++;
        if (nd !== 0) begin failures++; $display("FAIL midrun_no_done: got %0d dones want 0", nd); end
        run_div(4'd6, 4'd4, lat, nd);
        checks++;
        if (lat !== 5 || quotient !== 4'h1 || remainder !== 4'h2) begin
            failures++;
            $display("FAIL after_reset_6_4: got lat=%0d q=%h r=%h want lat=5 q=1 r=2",
                     lat, quotient, remainder);
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        int lat, nd;
        run_div(4'h9, 4'h2, lat, nd);
        checks++;
        if (lat !== 5 || quotient !== 4'hD || remainder !== 4'hF) begin
            failures++;
            $display("FAIL signed_m7_2: got lat=%0d q=%h r=%h want lat=5 q=d r=f",
                     lat, quotient, remainder);
        end
        run_div(4'h8, 4'hF, lat, nd);
        checks++;
        if (quotient !== 4'h8 || remainder !== 4'h0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL signed_m8_m1: got q=%h r=%h dbz=%b want q=8 r=0 dbz=0",
                     quotient, remainder, div_by_zero);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_div_zero();
        test_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle restoring divider that inverts the team's combinational adder/subtractor path: where that unit produces a sum or difference in one pass, this block recovers quotient and remainder by iterated shift-and-subtract over the same ripple add/sub datapath. It sits beside the adder/subtractor in the arithmetic cluster. A start/busy/done handshake lets a controller issue one division at a time.

## Interface
- `WIDTH`, 4: operand, quotient and remainder width in bits (≥2).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  WIDTH  captured on accepted `start`.
- `divisor`  in  WIDTH  captured on accepted `start`.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `quotient`  out  WIDTH  held until next accepted `start`.
- `remainder`  out  WIDTH  held until next accepted `start`.
- `div_by_zero`  out  1  set with `done` when divisor was 0; held like results.

## Operation
- **Reset:** all outputs are 0 and state is IDLE. Reset mid-operation aborts with no `done`.
- **FSM:** IDLE → RUN on `start` with a nonzero divisor. IDLE → DONE on `start` with a zero divisor. RUN → DONE when the iteration counter reaches 0. DONE → IDLE unconditionally.
- **Accept:** in IDLE with `start`=1, latch the operands and clear the quotient register. Clear partial remainder R (WIDTH+1 bits). Set counter = WIDTH.
- **RUN iteration (one per cycle):**
  - R ← {R[WIDTH-1:0], Q[WIDTH-1]}; Q ← Q<<1.
  - trial = R − {0,D} via add/sub, with mode=1 (invert D, carry-in 1).
  - If the add/sub carry-out is 1 (no borrow): R ← trial, Q[0] ← 1. Otherwise R is unchanged and Q[0] ← 0.
  - Counter decrements.
- **DONE:** `quotient`=Q and `remainder`=R[WIDTH-1:0]. `done`=1 for this cycle only.
- **Divide by zero:** `quotient` = all ones, `remainder` = dividend, `div_by_zero`=1. Otherwise `div_by_zero`=0.
- **Ignored start:** `start` while `busy` is ignored; no queueing. `start` in the DONE cycle is also ignored.
- **Operand stability:** operand changes after acceptance have no effect.

## Timing
- Start accepted at edge N. The WIDTH RUN cycles cover edges N+1..N+WIDTH. `done` is high in the cycle after edge N+WIDTH, so latency is WIDTH+1 cycles.
- Divide-by-zero latency is 1 cycle: `done` is high in the cycle after edge N.
- The earliest next accepted `start` is the edge ending the DONE cycle plus one; `busy` is low by then.
- The add/sub chain is combinational within one cycle; the critical path is WIDTH+1 ripple stages.

## Configuration
- **`DIV_SIGNED_EN` defined:** operands and results are two's complement.
  - Magnitudes are taken on accept.
  - Signs are fixed in the DONE cycle: quotient truncates toward zero, and the remainder takes the dividend's sign.
  - Most-negative ÷ −1 yields quotient = most-negative and remainder = 0, with no flag.
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Latency is unchanged.
- **Not defined:** unsigned only. No sign logic is synthesized.

## Structure
- Shared package `arith_pkg`:
  - FSM state enum (IDLE, RUN, DONE).
  - Default `WIDTH` constant.
  - Counter width constant, $clog2(WIDTH+1).
- One sub-module, `addsub_w`: a parameterized ripple adder/subtractor.
  - Ports: a, b, mode → sum, cout. Each b bit is XORed with mode; carry-in = mode.
  - Instantiated once at width WIDTH+1.

## Test plan
- 13 ÷ 3 (WIDTH=4) → `done` 5 cycles after start; quotient=4, remainder=1, div_by_zero=0.
- 7 ÷ 0 → `done` after 1 cycle; quotient=15, remainder=7, div_by_zero=1.
- 15 ÷ 1 and 0 ÷ 5 → quotient 15 / remainder 0, then quotient 0 / remainder 0. Results hold until the next start.
- Start pulsed every cycle during a 9 ÷ 2 run → only one `done`, with quotient=4 and remainder=1. Operands changed mid-run have no effect.
- `rst` asserted in the 2nd RUN cycle → next cycle has all outputs 0 and IDLE; no `done`. A fresh 6 ÷ 4 then yields quotient 1, remainder 2.
- With `DIV_SIGNED_EN`:
  - −7 ÷ 2 → quotient −3 (4'hD), remainder −1 (4'hF).
  - −8 ÷ −1 → quotient 4'h8, remainder 0.
